div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one iterative `div_unit` between `NUM_REQ` execution pipes. It arbitrates among pending DIV/DIVU/MOD/MODU requests round-robin, sequences the divider's start/done handshake, and holds each result until the owning pipe advances. It also absorbs flushes that arrive mid-division, since the divider cannot be aborted. The block sits between the EX stages and the single divider instance; EX keeps `advance_ready` low while its request is pending.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesting EX pipes (index 0 = oldest pipe).
- `DATA_WIDTH`, 32, operand/result width.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-pipe division request. Held, with stable operands, until response consumed or pipe flushed.
- `req_op_i`  in  NUM_REQ×3  div_op encoding: 4 DIV, 5 DIVU, 6 MOD, 7 MODU.
- `req_dividend_i`, `req_divisor_i`  in  NUM_REQ×DATA_WIDTH  operands.
- `flush_i`  in  NUM_REQ  per-pipe flush. Cancels that pipe's request.
- `advance_i`  in  NUM_REQ  per-pipe advance. Consumes a valid response.
- `resp_valid_o`  out  NUM_REQ  result ready for that pipe (one-hot or zero).
- `resp_data_o`  out  DATA_WIDTH  result for the pipe flagged in `resp_valid_o`.
- `busy_o`  out  1  state ≠ IDLE.
- `div_start_o`  out  1  one-cycle start pulse to divider.
- `div_op_o`  out  2  `op[1:0]` of the granted request.
- `div_dividend_o`, `div_divisor_o`  out  DATA_WIDTH  latched operands. The divisor is replaced by 1 when zero.
- `div_is_running_i`, `div_done_i`  in  1  divider status.
- `div_quotient_i`, `div_remainder_i`  in  DATA_WIDTH  divider results.

## Operation
- State machine: IDLE → START → WAIT → RESP → IDLE. Kill path: START/WAIT → DRAIN → IDLE.
- **IDLE:**
  - A request is eligible when `req_valid_i[i] & ~flush_i[i]`.
  - If any request is eligible and `div_is_running_i`=0, grant the first eligible index at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On grant, latch the owner, op and operands, set `rr_ptr <= owner+1` (wrap), and go to START.
- **START:** `div_start_o`=1 for exactly this cycle, then go to WAIT.
- **WAIT:**
  - On `div_done_i`, capture the result: quotient for op 4/5, remainder for op 6/7. Then go to RESP.
- **RESP:**
  - `resp_valid_o[owner]`=1 and `resp_data_o` = captured result, both held stable.
  - On `advance_i[owner]` or `flush_i[owner]`, go to IDLE.
- **Kill:** `flush_i[owner]` in START or WAIT sets the kill condition and moves to DRAIN.
  - START still issues its start pulse, so the divider is never left half-started.
  - If `div_done_i` arrives in the same cycle as the flush, kill wins: go directly to IDLE with no response.
- **DRAIN:** wait for `div_done_i`, discard the result, go to IDLE. No response is ever produced for a killed request.
- Flushes of non-owner pipes have no effect on the current operation.
- Operands are latched at grant; later changes on the `req_*` inputs are ignored until the next grant.
- `div_op_o`, `div_dividend_o` and `div_divisor_o` hold their latched values from grant until the next grant.

## Timing
- Reset state:
  - state IDLE, `rr_ptr`=0.
  - Outputs: `resp_valid_o`=0, `resp_data_o`=0, `div_start_o`=0, `div_op_o`=0, `div_dividend_o`=0, `div_divisor_o`=0, `busy_o`=0.
- Reset mid-operation returns to IDLE immediately. The divider is reset by the same `rst`.
- All outputs are registered or decoded from registered state; there is no combinational path from `req_*` to `div_*`.
- Latency for request valid at cycle T (IDLE, divider free):
  - grant at the T edge;
  - `div_start_o` high in T+1;
  - divider done at D;
  - `resp_valid_o` high from D+1.
- Back-to-back: `advance_i` at cycle R returns to IDLE at R+1. The next grant is decided in R+1, so the next start pulse is at R+2.
- `resp_valid_o` never drops without `advance_i`/`flush_i` of the owner or `rst`.
- `div_start_o` is never asserted while `div_is_running_i`=1.

## Test plan
- **Single request:** pipe0 DIV 100/7 → one `div_start_o` pulse one cycle after request; `resp_valid_o`=01, `resp_data_o`=14 held until `advance_i[0]`; `busy_o` drops the cycle after.
- **Contention and round-robin:**
  - Pipe0 MOD 100/7 and pipe1 DIVU 0xFFFFFFFF/2 asserted together with `rr_ptr`=0 → pipe0 served first, result 2.
  - Then pipe1 is served (0x7FFFFFFF) while pipe0 re-requests; pipe0 is served only after pipe1 is consumed.
- **Flush mid-division:**
  - `flush_i[0]` in WAIT → no `resp_valid_o`, state DRAIN until `div_done_i`, then IDLE.
  - A pending pipe1 request gets `div_start_o` only after that done.
- **Flush coincident with done:** kill wins, no response, IDLE next cycle.
- **Divide by zero:** MODU 5/0 → `div_divisor_o`=1, response 0 (remainder of 5/1), no hang.
- **Reset during WAIT:** all outputs 0 next cycle, and a subsequent request completes normally.

Source files
------------

// File: rtl/div_arbiter.sv
// Shares one iterative divider among NUM_REQ EX pipes: round-robin grant, start/done sequencing,
// result hold until the owner advances, and drain of flushed in-flight divisions.
module div_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ-1:0][2:0]              req_op_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_dividend_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_divisor_i,
  input  logic [NUM_REQ-1:0]                   flush_i,
  input  logic [NUM_REQ-1:0]                   advance_i,
  output logic [NUM_REQ-1:0]                   resp_valid_o,
  output logic [DATA_WIDTH-1:0]                resp_data_o,
  output logic                                 busy_o,
  output logic                                 div_start_o,
  output logic [1:0]                           div_op_o,
  output logic [DATA_WIDTH-1:0]                div_dividend_o,
  output logic [DATA_WIDTH-1:0]                div_divisor_o,
  input  logic                                 div_is_running_i,
  input  logic                                 div_done_i,
  input  logic [DATA_WIDTH-1:0]                div_quotient_i,
  input  logic [DATA_WIDTH-1:0]                div_remainder_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic               grant_any;
  logic [NUM_REQ-1:0] eligible;

  assign eligible = req_valid_i & ~flush_i;
  assign busy_o   = (state != S_IDLE);
  assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  // First eligible pipe at or after rr_ptr, wrapping.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(rr_ptr) + off) % NUM_REQ;
      if (!grant_any && eligible[IDX_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      resp_valid_o   <= '0;
      resp_data_o    <= '0;
      div_start_o    <= 1'b0;
      div_op_o       <= '0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
    end else begin
      div_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any && !div_is_running_i) begin
            owner          <= grant_idx;
            div_op_o       <= req_op_i[grant_idx][1:0];
            div_dividend_o <= req_dividend_i[grant_idx];
            div_divisor_o  <= (req_divisor_i[grant_idx] == '0) ? DATA_WIDTH'(1)
                                                                : req_divisor_i[grant_idx];
            rr_ptr         <= ptr_next;
            div_start_o    <= 1'b1;
            state          <= S_START;
          end
        end
        // The start pulse is already on the wire; a kill here still lets it go out.
        S_START: state <= flush_i[owner] ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          if (flush_i[owner]) begin
            state <= div_done_i ? S_IDLE : S_DRAIN;
          end else if (div_done_i) begin
            resp_data_o  <= div_op_o[1] ? div_remainder_i : div_quotient_i;
            resp_valid_o <= NUM_REQ'(1) << owner;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (advance_i[owner] || flush_i[owner]) begin
            resp_valid_o <= '0;
            state        <= S_IDLE;
          end
        end
        S_DRAIN: if (div_done_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed and randomized bench for div_arbiter with a behavioural divider and result model.
module tb_div_arbiter;
  localparam int N = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         req_valid, flush, advance, resp_valid;
  logic [N-1:0][2:0]    req_op;
  logic [N-1:0][W-1:0]  req_dividend, req_divisor;
  logic [W-1:0]         resp_data, div_dividend, div_divisor, div_quotient, div_remainder;
  logic                 busy, div_start, div_running, div_done;
  logic [1:0]           div_op;

  int n_total = 0, n_pass = 0, n_starts = 0, cyc = 0, div_lat = 3, lat_cnt = 0;

  div_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_op_i(req_op),
    .req_dividend_i(req_dividend), .req_divisor_i(req_divisor),
    .flush_i(flush), .advance_i(advance),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .busy_o(busy),
    .div_start_o(div_start), .div_op_o(div_op),
    .div_dividend_o(div_dividend), .div_divisor_o(div_divisor),
    .div_is_running_i(div_running), .div_done_i(div_done),
    .div_quotient_i(div_quotient), .div_remainder_i(div_remainder)
  );

  // Iterative divider stand-in: busy for div_lat cycles after start, then a one-cycle done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) n_starts <= n_starts + 1;
    div_done <= 1'b0;
    if (rst) begin
      div_running   <= 1'b0;
      lat_cnt       <= 0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      div_running <= 1'b1;
      lat_cnt     <= div_lat;
    end else if (div_running) begin
      if (lat_cnt <= 1) begin
        div_running <= 1'b0;
        div_done    <= 1'b1;
        if (div_op[0]) begin
          div_quotient  <= div_dividend / div_divisor;
          div_remainder <= div_dividend % div_divisor;
        end else begin
          div_quotient  <= $unsigned($signed(div_dividend) / $signed(div_divisor));
          div_remainder <= $unsigned($signed(div_dividend) % $signed(div_divisor));
        end
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [W-1:0] d;
    d = (b == '0) ? W'(1) : b;
    case (op)
      3'd4:    return $unsigned($signed(a) / $signed(d));
      3'd5:    return a / d;
      3'd6:    return $unsigned($signed(a) % $signed(d));
      default: return a % d;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_resp(input string tag);
    int k;
    k = 0;
    while (resp_valid == '0 && k < 200) begin
      tick();
      k++;
    end
    if (resp_valid == '0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic set_req(input int p, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[p]       = op;
    req_dividend[p] = a;
    req_divisor[p]  = b;
    req_valid[p]    = 1'b1;
  endtask

  task automatic consume(input int p);
    advance[p] = 1'b1;
    tick();
    advance[p]   = 1'b0;
    req_valid[p] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_start"}, div_start, 0);
    check({tag, "_op"}, div_op, 0);
    check({tag, "_dividend"}, div_dividend, 0);
    check({tag, "_divisor"}, div_divisor, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) if (!rst && div_start) check("start_while_running", div_running, 0);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s0, done_c, start_c, exp_owner, ptr, k;
    logic saw;
    logic [N-1:0] pend;
    logic [2:0]   rop [N];
    logic [W-1:0] ra [N], rb [N];

    rst = 1'b1; req_valid = '0; flush = '0; advance = '0;
    req_op = '0; req_dividend = '0; req_divisor = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single DIV 100/7 on pipe0
    s0 = n_starts;
    set_req(0, 3'd4, 100, 7);
    tick();
    check("single_start", div_start, 1);
    check("single_busy", busy, 1);
    check("single_op", div_op, 0);
    check("single_dividend", div_dividend, 100);
    check("single_divisor", div_divisor, 7);
    wait_resp("single");
    check("single_valid", resp_valid, 2'b01);
    check("single_data", resp_data, 14);
    check("single_one_start", n_starts - s0, 1);
    repeat (3) tick();
    check("single_hold_valid", resp_valid, 2'b01);
    check("single_hold_data", resp_data, 14);
    consume(0);
    check("single_release_valid", resp_valid, 0);
    check("single_release_busy", busy, 0);

    // Divide by zero: MODU 5/0 on pipe1
    set_req(1, 3'd7, 5, 0);
    tick();
    check("dz_start", div_start, 1);
    check("dz_divisor", div_divisor, 1);
    check("dz_op", div_op, 3);
    check("dz_dividend", div_dividend, 5);
    wait_resp("dz");
    check("dz_valid", resp_valid, 2'b10);
    check("dz_data", resp_data, 0);
    consume(1);

    // Contention with rr_ptr back at 0
    set_req(0, 3'd6, 100, 7);
    set_req(1, 3'd5, 32'hFFFF_FFFF, 2);
    tick();
    check("cont_start0", div_start, 1);
    check("cont_dividend0", div_dividend, 100);
    wait_resp("cont0");
    check("cont_valid0", resp_valid, 2'b01);
    check("cont_data0", resp_data, 2);
    advance[0] = 1'b1;
    tick();
    advance[0] = 1'b0;
    set_req(0, 3'd4, 50, 5);
    s0 = n_starts;
    check("b2b_gap", div_start, 0);
    tick();
    check("b2b_start", div_start, 1);
    check("cont_dividend1", div_dividend, 32'hFFFF_FFFF);
    wait_resp("cont1");
    check("cont_valid1", resp_valid, 2'b10);
    check("cont_data1", resp_data, 32'h7FFF_FFFF);
    check("cont_pipe0_waits", n_starts - s0, 1);
    consume(1);
    tick();
    check("cont_start2", div_start, 1);
    check("cont_dividend2", div_dividend, 50);
    wait_resp("cont2");
    check("cont_valid2", resp_valid, 2'b01);
    check("cont_data2", resp_data, 10);
    consume(0);

    // Flush of the owner while the divider is running
    div_lat = 8;
    set_req(0, 3'd4, 100, 7);
    tick();
    tick();
    flush[0] = 1'b1;
    set_req(1, 3'd5, 9, 3);
    tick();
    flush[0] = 1'b0;
    req_valid[0] = 1'b0;
    check("flush_busy", busy, 1);
    check("flush_valid", resp_valid, 0);
    done_c = -100; start_c = -1; saw = 1'b0;
    for (int i = 0; i < 60 && start_c < 0; i++) begin
      if (resp_valid != '0) saw = 1'b1;
      if (div_done) done_c = cyc;
      if (div_start) start_c = cyc;
      if (start_c < 0) tick();
    end
    check("flush_no_resp", saw, 0);
    check("flush_restart_gap", start_c - done_c, 2);
    check("flush_next_dividend", div_dividend, 9);
    div_lat = 3;
    wait_resp("flush_next");
    check("flush_next_valid", resp_valid, 2'b10);
    check("flush_next_data", resp_data, 3);
    consume(1);

    // Flush in the same cycle as done
    set_req(0, 3'd5, 20, 4);
    k = 0;
    while (!div_done && k < 60) begin
      tick();
      k++;
    end
    check("coinc_done_seen", div_done, 1);
    flush[0] = 1'b1;
    req_valid[0] = 1'b0;
    tick();
    flush[0] = 1'b0;
    check("coinc_busy", busy, 0);
    check("coinc_valid", resp_valid, 0);
    repeat (3) tick();
    check("coinc_valid_later", resp_valid, 0);

    // Reset during WAIT, then a normal completion
    div_lat = 8;
    set_req(1, 3'd4, 30, 6);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    div_lat = 3;
    tick();
    check("midreset_start", div_start, 1);
    check("midreset_dividend", div_dividend, 30);
    wait_resp("midreset");
    check("midreset_valid", resp_valid, 2'b10);
    check("midreset_data", resp_data, 5);
    consume(1);

    // Randomized requests against a round-robin/arithmetic model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr = 0;
    for (int it = 0; it < 16; it++) begin
      div_lat = $urandom_range(1, 6);
      pend = N'($urandom_range(1, 3));
      for (int p = 0; p < N; p++) begin
        if (pend[p]) begin
          rop[p] = 3'(4 + $urandom_range(0, 3));
          ra[p]  = $urandom;
          rb[p]  = ($urandom_range(0, 3) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
          if (ra[p] == 32'h8000_0000 && rb[p] == '1) rb[p] = 3;
          set_req(p, rop[p], ra[p], rb[p]);
        end
      end
      while (pend != '0) begin
        exp_owner = -1;
        for (int o = 0; o < N; o++) begin
          if (exp_owner < 0 && pend[(ptr + o) % N]) exp_owner = (ptr + o) % N;
        end
        wait_resp("rand");
        check("rand_valid", resp_valid, N'(1) << exp_owner);
        check("rand_data", resp_data, ref_result(rop[exp_owner], ra[exp_owner], rb[exp_owner]));
        consume(exp_owner);
        pend[exp_owner] = 1'b0;
        ptr = (exp_owner + 1) % N;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
